ref_clk_nco: RTL

- Numerically controlled reference-clock generator; the transmit-side counterpart of the team's DPLL.
- Synthesises a programmable-frequency square wave (plus an 8x companion) from the master clock with a phase accumulator.
- Feeds the DPLL's clk_fin input in loopback and bring-up builds.
- Frequency and phase-step updates arrive over a valid/ready config port and are applied glitch-free at a wrap boundary.

---
 rtl/ref_clk_nco_if.sv | 12 +
 rtl/ref_clk_nco.sv | 103 ++++++++++
 2 files changed

// File: rtl/ref_clk_nco_if.sv
// Config port for the reference-clock NCO: new increment plus one-shot phase step.
interface ref_clk_nco_if #(
   parameter int ACC_W = 16
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [ACC_W-1:0] cfg_inc;
   logic [ACC_W-1:0] cfg_phase;

   modport master (output cfg_valid, cfg_inc, cfg_phase, input  cfg_ready);
   modport slave  (input  cfg_valid, cfg_inc, cfg_phase, output cfg_ready);
endinterface

// File: rtl/ref_clk_nco.sv
// Phase-accumulator reference clock (f = f_clk*inc/2^ACC_W) with glitch-free config apply at wrap.
// Optional REF_NCO_DITHER_EN adds an LFSR bit to every accumulator step for deterministic jitter.
module ref_clk_nco #(
   parameter int               ACC_W       = 16,
   parameter logic [ACC_W-1:0] INC_DEFAULT = 'h0800
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   ref_clk_nco_if.slave cfg,
   output logic        clk_ref_out,
   output logic        clk8x_ref_out,
   output logic        ref_edge,
   output logic        cfg_pending
);
   typedef enum logic {IDLE, PENDING} state_e;

   state_e           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] inc_q, inc_d;
   logic [ACC_W-1:0] pend_inc_q, pend_inc_d;
   logic [ACC_W-1:0] pend_phase_q, pend_phase_d;
   logic             edge_q, edge_d;
   logic [ACC_W:0]   sum;
   logic             dith, wrap, accept, apply;

`ifdef REF_NCO_DITHER_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (en) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   always_ff @(posedge clk) begin
      if (reset) lfsr_q <= 16'hACE1;
      else       lfsr_q <= lfsr_d;
   end

   assign dith = lfsr_q[0];
`else
   assign dith = 1'b0;
`endif

   // Ready is gated by reset so it reads low for the whole reset window.
   assign cfg.cfg_ready = (state_q == IDLE) && !reset;

   always_comb begin
      sum          = {1'b0, acc_q} + {1'b0, inc_q} + {{ACC_W{1'b0}}, dith};
      wrap         = en && sum[ACC_W];
      accept       = cfg.cfg_valid && cfg.cfg_ready;
      apply        = (state_q == PENDING) && (wrap || !en);
      state_d      = state_q;
      pend_inc_d   = pend_inc_q;
      pend_phase_d = pend_phase_q;
      inc_d        = inc_q;
      acc_d        = en ? sum[ACC_W-1:0] : '0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               pend_inc_d   = cfg.cfg_inc;
               pend_phase_d = cfg.cfg_phase;
               state_d      = PENDING;
            end
         end
         PENDING: begin
            if (apply) begin
               // The step into the wrap still uses the old increment; phase only lands while running.
               if (en) acc_d = sum[ACC_W-1:0] + pend_phase_q;
               inc_d   = pend_inc_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      edge_d = acc_d[ACC_W-1] & ~acc_q[ACC_W-1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         acc_q        <= '0;
         inc_q        <= INC_DEFAULT;
         pend_inc_q   <= '0;
         pend_phase_q <= '0;
         edge_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         inc_q        <= inc_d;
         pend_inc_q   <= pend_inc_d;
         pend_phase_q <= pend_phase_d;
         edge_q       <= edge_d;
      end
   end

   assign clk_ref_out   = acc_q[ACC_W-1];
   assign clk8x_ref_out = acc_q[ACC_W-4];
   assign ref_edge      = edge_q;
   assign cfg_pending   = (state_q == PENDING);
endmodule
